// File: rtl/mont_exp_ctrl_pkg.sv
// Shared types for the Montgomery exponentiation sequencer: FSM encoding,
// operation codes and default widths.
package mont_exp_ctrl_pkg;

  localparam int WIDTH_DEF   = 1024;
  localparam int E_WIDTH_DEF = 1024;
  localparam int LW_DEF      = 11;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SQ_ISSUE   = 3'd1,
    SQ_WAIT    = 3'd2,
    MUL_ISSUE  = 3'd3,
    MUL_WAIT   = 3'd4,
    POST_ISSUE = 3'd5,
    POST_WAIT  = 3'd6,
    DONE       = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    OP_SQ   = 2'd0,
    OP_MUL  = 2'd1,
    OP_POST = 2'd2,
    OP_NONE = 2'd3
  } op_t;

  // ISSUE state that launches a given multiplier operation
  function automatic state_t issue_state(input op_t op);
    case (op)
      OP_SQ:   return SQ_ISSUE;
      OP_MUL:  return MUL_ISSUE;
      OP_POST: return POST_ISSUE;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/mont_exp_ctrl_scanner.sv
// Exponent bit scanner: holds the exponent, walks the bit index from the
// most significant processed bit down to 0 and presents e[idx].
module mont_exp_ctrl_scanner #(
  parameter int E_WIDTH = 1024,
  parameter int LW      = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [E_WIDTH-1:0] e,
  input  logic [LW-1:0]      e_len,
  output logic               bit_val,
  output logic               last,
  output logic               empty
);

  localparam int IW = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;

  logic [E_WIDTH-1:0] e_r;
  logic [IW-1:0]      idx_r;
  logic [LW-1:0]      len_s;

  assign len_s   = (e_len > LW'(E_WIDTH)) ? LW'(E_WIDTH) : e_len;
  assign empty   = (len_s == {LW{1'b0}});
  assign bit_val = e_r[idx_r];
  assign last    = (idx_r == {IW{1'b0}});

  // exponent capture and index down-counter; truncation maps E_WIDTH-1 correctly
  always_ff @(posedge clk) begin
    if (reset) begin
      e_r   <= {E_WIDTH{1'b0}};
      idx_r <= {IW{1'b0}};
    end else if (load) begin
      e_r   <= e;
      idx_r <= IW'(len_s - LW'(1));
    end else if (step) begin
      idx_r <= idx_r - IW'(1);
    end
  end

endmodule

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer for X^E mod M in the Montgomery
// domain, driving one shared Montgomery multiplier through a start/done handshake.
module mont_exp_ctrl
  import mont_exp_ctrl_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int E_WIDTH = E_WIDTH_DEF,
  parameter int LW      = LW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_r,
  input  logic [WIDTH-1:0]   in_m,
  input  logic [E_WIDTH-1:0] in_e,
  input  logic [LW-1:0]      in_e_len,
  output logic [WIDTH-1:0]   result,
  output logic               done,
  output logic               busy,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  output logic [WIDTH-1:0]   mul_m,
  input  logic [WIDTH-1:0]   mul_result,
  input  logic               mul_done
);

  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_r, state_s;
  op_t              op_s;
  logic [WIDTH-1:0] acc_r, acc_s, x_r, m_r, b_s;
  logic [WIDTH-1:0] mul_a_r, mul_b_r, result_r;
  logic             mul_start_r, done_r, busy_r;
  logic             load_s, step_s, capture_s;
  logic             bit_s, last_s, empty_s;

  mont_exp_ctrl_scanner #(.E_WIDTH(E_WIDTH), .LW(LW)) u_scanner (
    .clk     (clk),
    .reset   (rst),
    .load    (load_s),
    .step    (step_s),
    .e       (in_e),
    .e_len   (in_e_len),
    .bit_val (bit_s),
    .last    (last_s),
    .empty   (empty_s)
  );

  // next state, next accumulator and the operation to launch this edge
  always_comb begin
    state_s   = state_r;
    acc_s     = acc_r;
    op_s      = OP_NONE;
    load_s    = 1'b0;
    step_s    = 1'b0;
    capture_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          load_s  = 1'b1;
          acc_s   = in_r;
          op_s    = empty_s ? OP_POST : OP_SQ;
          state_s = issue_state(op_s);
        end else begin
          state_s = IDLE;
        end
      end
      SQ_ISSUE:   state_s = SQ_WAIT;
      SQ_WAIT: begin
        if (mul_done) begin
          acc_s = mul_result;
          if (bit_s) begin
            op_s = OP_MUL;
          end else if (last_s) begin
            op_s = OP_POST;
          end else begin
            op_s   = OP_SQ;
            step_s = 1'b1;
          end
          state_s = issue_state(op_s);
        end else begin
          state_s = SQ_WAIT;
        end
      end
      MUL_ISSUE:  state_s = MUL_WAIT;
      MUL_WAIT: begin
        if (mul_done) begin
          acc_s = mul_result;
          if (last_s) begin
            op_s = OP_POST;
          end else begin
            op_s   = OP_SQ;
            step_s = 1'b1;
          end
          state_s = issue_state(op_s);
        end else begin
          state_s = MUL_WAIT;
        end
      end
      POST_ISSUE: state_s = POST_WAIT;
      POST_WAIT: begin
        if (mul_done) begin
          acc_s     = mul_result;
          capture_s = 1'b1;
          state_s   = DONE;
        end else begin
          state_s = POST_WAIT;
        end
      end
      DONE:       state_s = IDLE;
      default:    state_s = IDLE;
    endcase
  end

  // operand B for the operation being launched
  always_comb begin
    case (op_s)
      OP_SQ:   b_s = acc_s;
      OP_MUL:  b_s = x_r;
      OP_POST: b_s = ONE_W;
      default: b_s = mul_b_r;
    endcase
  end

  // state, accumulator and all outputs; operands only change on a launch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      acc_r       <= {WIDTH{1'b0}};
      x_r         <= {WIDTH{1'b0}};
      m_r         <= {WIDTH{1'b0}};
      mul_a_r     <= {WIDTH{1'b0}};
      mul_b_r     <= {WIDTH{1'b0}};
      result_r    <= {WIDTH{1'b0}};
      mul_start_r <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      acc_r       <= acc_s;
      mul_start_r <= (op_s != OP_NONE);
      done_r      <= (state_s == DONE);
      busy_r      <= (state_s != IDLE);
      if (load_s) begin
        x_r <= in_x;
        m_r <= in_m;
      end
      if (op_s != OP_NONE) begin
        mul_a_r <= acc_s;
        mul_b_r <= b_s;
      end
      if (capture_s) begin
        result_r <= mul_result;
      end
    end
  end

  assign result    = result_r;
  assign done      = done_r;
  assign busy      = busy_r;
  assign mul_start = mul_start_r;
  assign mul_a     = mul_a_r;
  assign mul_b     = mul_b_r;
  assign mul_m     = m_r;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Directed bench for mont_exp_ctrl with a behavioural Montgomery multiplier
// of configurable latency.
module tb_mont_exp_ctrl;

  localparam int W  = 1024;
  localparam int EW = 1024;
  localparam int LW = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  in_x = '0, in_r = '0, in_m = '0;
  logic [EW-1:0] in_e = '0;
  logic [LW-1:0] in_e_len = '0;
  logic [W-1:0]  result, mul_a, mul_b, mul_m;
  logic          done, busy, mul_start;
  logic [W-1:0]  mul_result = '0;
  logic          model_done = 1'b0, inj_done = 1'b0;
  logic          mul_done;

  assign mul_done = model_done | inj_done;

  mont_exp_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .in_x(in_x), .in_r(in_r), .in_m(in_m),
    .in_e(in_e), .in_e_len(in_e_len), .result(result), .done(done), .busy(busy),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_m(mul_m),
    .mul_result(mul_result), .mul_done(mul_done)
  );

  always #5 clk = ~clk;

  int           total = 0, bad = 0, unstable = 0;
  int           cyc_cnt = 0, t0 = 0, lat = 3, mcnt = 0;
  logic         mbusy = 1'b0;
  logic [W-1:0] la, lb;
  logic [W-1:0] pa[$], pb[$];
  logic [W-1:0] m97, mrand, xrand, expv, ebits;
  int           cyc, n, seen;

  function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m);
    logic [W+1:0] t;
    t = '0;
    for (int i = 0; i < W; i++) begin
      if (a[i]) t = t + {2'b00, b};
      if (t[0]) t = t + {2'b00, m};
      t = t >> 1;
    end
    if (t >= {2'b00, m}) t = t - {2'b00, m};
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] to_mont(input logic [W-1:0] x, input logic [W-1:0] m);
    logic [2*W-1:0] p;
    p = {x, {W{1'b0}}} % {{W{1'b0}}, m};
    return p[W-1:0];
  endfunction

  function automatic logic [W-1:0] modexp(input logic [W-1:0] x, input logic [EW-1:0] e, input int elen, input logic [W-1:0] m);
    logic [2*W-1:0] r, mm, xx;
    r = 1; mm = {{W{1'b0}}, m}; xx = {{W{1'b0}}, x};
    for (int i = elen - 1; i >= 0; i--) begin
      r = (r * r) % mm;
      if (e[i]) r = (r * xx) % mm;
    end
    return r[W-1:0];
  endfunction

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // multiplier model: latches operands at launch, flags any operand movement while busy
  always @(posedge clk) begin
    model_done <= 1'b0;
    if (rst) begin
      mbusy <= 1'b0;
      mcnt  <= 0;
    end else if (mbusy) begin
      if (mul_a !== la || mul_b !== lb) unstable <= unstable + 1;
      if (mcnt == 1) begin
        model_done <= 1'b1;
        mul_result <= mont(mul_a, mul_b, mul_m);
        mbusy      <= 1'b0;
      end else begin
        mcnt <= mcnt - 1;
      end
    end else if (mul_start) begin
      la <= mul_a;
      lb <= mul_b;
      pa.push_back(mul_a);
      pb.push_back(mul_b);
      if (lat == 1) begin
        model_done <= 1'b1;
        mul_result <= mont(mul_a, mul_b, mul_m);
      end else begin
        mcnt  <= lat - 1;
        mbusy <= 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs[127:0], exp[127:0]);
    end
  endtask

  task automatic start_job(input logic [W-1:0] x, input logic [W-1:0] m, input logic [EW-1:0] e, input logic [LW-1:0] elen);
    @(negedge clk);
    in_m = m; in_x = to_mont(x, m); in_r = to_mont(W'(1), m);
    in_e = e; in_e_len = elen;
    pa.delete(); pb.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc_cnt;
  endtask

  task automatic wait_done(input int limit, output int c);
    int k;
    k = 0;
    while (done !== 1'b1 && k < limit) begin
      @(posedge clk); #1;
      k++;
    end
    c = (done === 1'b1) ? (cyc_cnt - t0 + 1) : -1;
  endtask

  task automatic check_ops(input string tag, input logic [EW-1:0] e, input int elen);
    int nexp, j, errs;
    nexp = elen + 1;
    for (int i = 0; i < elen; i++) if (e[i]) nexp++;
    check({tag, "_nops"}, pa.size(), nexp);
    if (pa.size() == nexp) begin
      j = 0; errs = 0;
      for (int i = elen - 1; i >= 0; i--) begin
        if (pa[j] !== pb[j]) errs++;
        j++;
        if (e[i]) begin
          if (pb[j] !== in_x) errs++;
          j++;
        end
      end
      if (pb[j] !== W'(1)) errs++;
      check({tag, "_opseq"}, errs, 0);
    end
  endtask

  initial begin
    m97 = W'(97);
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_mul_start", mul_start, 0);
    check("rst_result", result, 0);
    rst = 1'b0;

    // e=1011, L=3: S,M,S,S,M,S,M,P, 3^11 mod 97 = 25
    lat = 3;
    start_job(W'(3), m97, EW'(4'b1011), 11'd4);
    check("a_busy", busy, 1);
    wait_done(200, cyc);
    check("a_cycle", cyc, 33);
    check("a_result", result, 25);
    check_ops("a", EW'(4'b1011), 4);
    @(posedge clk); #1;
    check("a_done_pulse", {done, busy}, 0);

    // e_len=0: single POST with a=R mod M, b=1
    start_job(W'(3), m97, '1, 11'd0);
    wait_done(50, cyc);
    check("b_cycle", cyc, 5);
    check("b_result", result, 1);
    check_ops("b", '1, 0);
    if (pa.size() == 1) check("b_post_a", pa[0], in_r);
    @(posedge clk); #1;

    // spurious mul_done in IDLE and SQ_ISSUE, start hammered while busy, L=2
    lat = 2;
    @(negedge clk); inj_done = 1'b1;
    @(negedge clk); inj_done = 1'b0;
    check("c_idle_spurious", {done, busy, mul_start}, 0);
    start_job(W'(3), m97, EW'(4'b1011), 11'd4);
    inj_done = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    inj_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      start = (k % 2 == 1);
      @(posedge clk); #1;
    end
    start = 1'b0;
    wait_done(200, cyc);
    check("c_cycle", cyc, 25);
    check("c_result", result, 25);
    check_ops("c", EW'(4'b1011), 4);
    @(posedge clk); #1;

    // reset during MUL_WAIT, then e=5, e_len=3: 3^5 mod 97 = 49
    lat = 3;
    start_job(W'(3), m97, EW'(4'b1011), 11'd4);
    seen = mul_start ? 1 : 0;
    n = 0;
    while (seen < 2 && n < 100) begin
      @(posedge clk); #1;
      if (mul_start) seen++;
      n++;
    end
    check("d_reach_mul", seen, 2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("d_rst_ctl", {done, busy, mul_start}, 0);
    check("d_rst_result", result, 0);
    rst = 1'b0;
    start_job(W'(3), m97, EW'(3'b101), 11'd3);
    wait_done(200, cyc);
    check("d_cycle", cyc, 25);
    check("d_result", result, 49);
    check_ops("d", EW'(3'b101), 3);

    // back-to-back, L=1: 7^6 mod 97 = 85 then 3^11 mod 97 = 25
    @(posedge clk); #1;
    lat = 1;
    start_job(W'(7), m97, EW'(3'b110), 11'd3);
    wait_done(200, cyc);
    check("e1_result", result, 85);
    @(posedge clk); #1;
    start_job(W'(3), m97, EW'(4'b1011), 11'd4);
    check("e2_hold_start", result, 85);
    n = 0;
    while (pa.size() < 8 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("e2_hold_post", result, 85);
    wait_done(200, cyc);
    check("e2_cycle", cyc, 17);
    check("e2_result", result, 25);
    @(posedge clk); #1;

    // e_len above E_WIDTH saturates: 1024 squarings + 3 multiplies + post
    start_job(W'(3), m97, EW'(4'b1011), 11'd2047);
    wait_done(3000, cyc);
    check("f_cycle", cyc, 2057);
    check("f_result", result, 25);
    check_ops("f", EW'(4'b1011), 1024);
    @(posedge clk); #1;

    // full-width random modulus, e all ones over 1024 bits
    for (int i = 0; i < W / 32; i++) begin
      mrand[i*32 +: 32] = $urandom;
      xrand[i*32 +: 32] = $urandom;
    end
    mrand[W-1] = 1'b1;
    mrand[0]   = 1'b1;
    xrand      = xrand % mrand;
    ebits      = '1;
    expv       = modexp(xrand, ebits, 1024, mrand);
    start_job(xrand, mrand, ebits, 11'd1024);
    wait_done(5000, cyc);
    check("g_cycle", cyc, 4099);
    check("g_result", result, expv);
    check("g_nops", pa.size(), 2049);

    check("stable_operands", unstable, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
